// File: rtl/range_window_sequencer_if.sv
// range_window_sequencer_if
//  Bundles the sample stream, the RangeFinder control/result pins and the
//  result stream of range_window_sequencer.
//  slave  : sequencer side (consumes samples and finder results, drives finder and results)
//  master : environment side (sample producer, RangeFinder, result consumer)
//  Signals:
//   in_data/in_valid/in_ready            sample stream (valid/ready)
//   rf_data/rf_go/rf_finish              to RangeFinder data_in/go/finish
//   rf_range/rf_error                    from RangeFinder range/error
//   out_range/out_error/out_timeout      captured window result
//   out_valid/out_ready                  result handshake
//   busy                                 sequencer not idle
interface range_window_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rf_data;
  logic             rf_go;
  logic             rf_finish;
  logic [WIDTH-1:0] rf_range;
  logic             rf_error;
  logic [WIDTH-1:0] out_range;
  logic             out_error;
  logic             out_timeout;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  in_data, in_valid, rf_range, rf_error, out_ready,
    output in_ready, rf_data, rf_go, rf_finish,
           out_range, out_error, out_timeout, out_valid, busy
  );

  modport master (
    output in_data, in_valid, rf_range, rf_error, out_ready,
    input  in_ready, rf_data, rf_go, rf_finish,
           out_range, out_error, out_timeout, out_valid, busy
  );
endinterface

// File: rtl/range_window_sequencer.sv
// range_window_sequencer
//  Cuts a valid/ready sample stream into WINDOW_LEN-sample windows and drives the
//  RangeFinder go/finish/data_in for each window. The finder result is captured
//  RF_LATENCY cycles after finish and held on a valid/ready output until taken.
//  An open window that sees TIMEOUT consecutive idle cycles is closed early
//  (TIMEOUT=0 disables this).
//  Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   bus    range_window_sequencer_if.slave (sample in, finder pins, result out, busy)
module range_window_sequencer #(
  parameter int WIDTH      = 8,
  parameter int WINDOW_LEN = 4,   // 2..255
  parameter int RF_LATENCY = 1,   // 1..4
  parameter int TIMEOUT    = 16   // 0 disables, max 255
) (
  input logic                     clock,
  input logic                     reset,
  range_window_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_RES,
    S_HOLD
  } state_t;

  localparam logic [7:0] WL_M1  = 8'(WINDOW_LEN - 1);
  localparam bit         TMO_EN = (TIMEOUT != 0);
  // Guarded so a disabled timeout does not produce a negative constant.
  localparam logic [7:0] TMO_M1 = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;
  localparam logic [2:0] LAT    = 3'(RF_LATENCY);

  state_t           state_q, state_d;
  logic [7:0]       sample_cnt_q, sample_cnt_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH-1:0] out_range_q, out_range_d;
  logic             out_error_q, out_error_d;
  logic             out_timeout_q, out_timeout_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             acc;
  logic             rf_go, rf_finish;
  logic [WIDTH-1:0] rf_data;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_RUN);
  assign acc      = bus.in_valid & in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sample_cnt_q  <= '0;
      idle_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      last_q        <= '0;
      tmo_q         <= 1'b0;
      out_range_q   <= '0;
      out_error_q   <= 1'b0;
      out_timeout_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      last_q        <= last_d;
      tmo_q         <= tmo_d;
      out_range_q   <= out_range_d;
      out_error_q   <= out_error_d;
      out_timeout_q <= out_timeout_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Finder controls are combinational so the finder sees a sample in the same
  // cycle it is accepted; they are zero on every other cycle.
  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = sample_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    last_d        = last_q;
    tmo_d         = tmo_q;
    out_range_d   = out_range_q;
    out_error_d   = out_error_q;
    out_timeout_d = out_timeout_q;
    out_valid_d   = out_valid_q;
    rf_go         = 1'b0;
    rf_finish     = 1'b0;
    rf_data       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          rf_go        = 1'b1;
          rf_data      = bus.in_data;
          // Tracked from the first sample so a one-sample window that times out
          // replays its own sample rather than a stale one.
          last_d       = bus.in_data;
          sample_cnt_d = 8'd1;
          idle_cnt_d   = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (acc) begin
          rf_data      = bus.in_data;
          last_d       = bus.in_data;
          idle_cnt_d   = '0;
          sample_cnt_d = (sample_cnt_q == 8'hFF) ? sample_cnt_q : sample_cnt_q + 8'd1;
          if (sample_cnt_q == WL_M1) begin
            rf_finish = 1'b1;
            tmo_d     = 1'b0;
            lat_cnt_d = 3'd1;
            state_d   = S_WAIT_RES;
          end
        end else begin
          idle_cnt_d = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;
          // Forced close: finder gets the last sample again so its min/max is unchanged.
          if (TMO_EN && idle_cnt_q == TMO_M1) begin
            rf_finish = 1'b1;
            rf_data   = last_q;
            tmo_d     = 1'b1;
            lat_cnt_d = 3'd1;
            state_d   = S_WAIT_RES;
          end
        end
      end
      S_WAIT_RES: begin
        // lat_cnt is 1 in the first cycle after finish, so capture lands in the
        // cycle where the finder result has become valid.
        if (lat_cnt_q == LAT) begin
          out_range_d   = bus.rf_range;
          out_error_d   = bus.rf_error;
          out_timeout_d = tmo_q;
          out_valid_d   = 1'b1;
          state_d       = S_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.rf_go       = rf_go;
  assign bus.rf_finish   = rf_finish;
  assign bus.rf_data     = rf_data;
  assign bus.out_range   = out_range_q;
  assign bus.out_error   = out_error_q;
  assign bus.out_timeout = out_timeout_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule
